frame_capture_ctrl: RTL and testbench

//  Sequences the serial frame recorder in the TTC downlink path. Hunts a serial bit stream for
//  the attached sync marker, then gates exactly FRAME_BITS post-marker bits into the recorder
//  (cap_en/cap_bit). It then holds frame_done until the consumer acks. It also aborts stalled frames
//  and counts frames lost while the recorder is busy.

---
 rtl/frame_capture_ctrl.sv | 124 ++++++++++++
 tb/tb_frame_capture_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// Serial frame recorder sequencer: hunts for the sync marker, gates FRAME_BITS payload bits into
// the recorder and holds frame_done until acked. Define FRAME_SYNC_TOL_EN for error-tolerant sync.
module frame_capture_ctrl #(
  parameter int                  SYNC_LEN    = 32,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 32'h1ACFFC1D,
  parameter int                  FRAME_BITS  = 8288,
  parameter int                  TIMEOUT_CYC = 1024,
  parameter int                  CNT_W       = 14
`ifdef FRAME_SYNC_TOL_EN
  ,
  parameter int                  SYNC_TOL    = 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_ack,
  output logic             cap_en,
  output logic             cap_bit,
  output logic             frame_done,
  output logic             frame_abort,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [1:0]       state,
  output logic [7:0]       lost_cnt
);

  localparam logic [1:0] HUNT     = 2'd0;
  localparam logic [1:0] CAPTURE  = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;
  localparam logic [1:0] WAIT_ACK = 2'd3;

  localparam int               IDLE_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);

  // Only the newest SYNC_LEN-1 bits need storing; the incoming bit completes the window.
  logic [SYNC_LEN-2:0] sr;
  logic [SYNC_LEN-1:0] sr_next;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                match;

  assign sr_next = {sr, bit_in};

`ifdef FRAME_SYNC_TOL_EN
  localparam int ERR_W = $clog2(SYNC_LEN + 1);
  logic [SYNC_LEN-1:0] diff;
  logic [ERR_W-1:0]    err_cnt;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    diff    = sr_next ^ SYNC_WORD;
    err_cnt = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      err_cnt = err_cnt + ERR_W'(diff[i]);
    end
    match = (err_cnt <= ERR_W'(SYNC_TOL));
  end
`else
  assign match = (sr_next == SYNC_WORD);
`endif

  assign frame_done = (state == WAIT_ACK);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      sr          <= '0;
      idle_cnt    <= '0;
      bit_cnt     <= '0;
      cap_en      <= 1'b0;
      cap_bit     <= 1'b0;
      frame_abort <= 1'b0;
      lost_cnt    <= '0;
    end else begin
      cap_en      <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        HUNT: begin
          if (bit_valid) begin
            sr <= sr_next[SYNC_LEN-2:0];
            if (match) begin
              state    <= CAPTURE;
              bit_cnt  <= '0;
              idle_cnt <= '0;
            end
          end
        end
        CAPTURE: begin
          if (bit_valid) begin
            cap_en   <= 1'b1;
            cap_bit  <= bit_in;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            idle_cnt <= '0;
            if (bit_cnt == LAST_BIT) state <= FLUSH;
          end else if (idle_cnt == IDLE_LAST) begin
            // Stalled stream: drop the partial frame and resume hunting from a clean window.
            frame_abort <= 1'b1;
            state       <= HUNT;
            bit_cnt     <= '0;
            sr          <= '0;
            idle_cnt    <= '0;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        FLUSH: state <= WAIT_ACK;
        default: begin
          // Markers seen while the recorder is full are counted as lost, never captured.
          if (bit_valid) begin
            sr <= sr_next[SYNC_LEN-2:0];
            if (match && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
          end
          if (frame_ack) begin
            state <= HUNT;
            sr    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl: captured bits are scoreboarded through a queue,
// control outputs are checked inline by one task per scenario.
`timescale 1ns/1ps
module tb_frame_capture_ctrl;

  localparam logic [31:0] SYNC_WORD   = 32'h1ACFFC1D;
  localparam int          FRAME_BITS  = 8288;
  localparam int          TIMEOUT_CYC = 1024;
  localparam int          CNT_W       = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic             bit_in;
  logic             bit_valid;
  logic             frame_ack;
  logic             cap_en;
  logic             cap_bit;
  logic             frame_done;
  logic             frame_abort;
  logic [CNT_W-1:0] bit_cnt;
  logic [1:0]       state;
  logic [7:0]       lost_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int cap_pulses   = 0;
  int abort_pulses = 0;
  bit exp_q[$];

  frame_capture_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .frame_ack   (frame_ack),
    .cap_en      (cap_en),
    .cap_bit     (cap_bit),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .bit_cnt     (bit_cnt),
    .state       (state),
    .lost_cnt    (lost_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every cap_en pulse must deliver the oldest expected payload bit.
  always @(negedge clk) begin
    bit exp_b;
    if (cap_en) begin
      cap_pulses++;
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cap_unexpected: cap_en=1 cap_bit=%0b, expected no capture", cap_bit);
      end else begin
        exp_b = exp_q.pop_front();
        if (cap_bit !== exp_b) begin
          n_fail++;
          $display("FAIL cap_bit: got %0b want %0b (pulse %0d)", cap_bit, exp_b, cap_pulses);
        end
      end
    end
    if (frame_abort) abort_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input bit b, input bit ack);
    bit_in    = b;
    bit_valid = 1'b1;
    frame_ack = ack;
    tick();
    bit_valid = 1'b0;
    frame_ack = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_marker(input logic [31:0] word);
    for (int i = 31; i >= 0; i--) drive(word[i], 1'b0);
  endtask

  // Payload bits are pushed to the scoreboard as they are driven; no gap after the last one.
  task automatic send_payload(input int n, input int gap, input bit alternating);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = alternating ? ((i % 2) == 0) : 1'($urandom());
      exp_q.push_back(b);
      drive(b, 1'b0);
      if (i != n - 1) idle(gap);
    end
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_ack = 1'b0;
    idle(3);
    n_assert++;
    if ({cap_en, cap_bit, frame_done, frame_abort, bit_cnt, state, lost_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: cap_en=%0b cap_bit=%0b done=%0b abort=%0b bit_cnt=%0d state=%0d lost=%0d, want all 0",
               cap_en, cap_bit, frame_done, frame_abort, bit_cnt, state, lost_cnt);
    end
    rst = 1'b0;
    idle(2);
    n_assert++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
  endtask

  task automatic test_frame_slow();
    int p0 = cap_pulses;
    send_marker(SYNC_WORD);
    n_assert++;
    if (state !== 2'd1 || bit_cnt !== '0) begin
      n_fail++; $display("FAIL t1_enter_capture: state=%0d bit_cnt=%0d want 1/0", state, bit_cnt);
    end
    send_payload(FRAME_BITS, 3, 1'b1);
    n_assert++;
    if (cap_en !== 1'b1 || state !== 2'd2 || frame_done !== 1'b0 || bit_cnt !== CNT_W'(FRAME_BITS)) begin
      n_fail++;
      $display("FAIL t1_last_bit: cap_en=%0b state=%0d done=%0b bit_cnt=%0d want 1/2/0/%0d",
               cap_en, state, frame_done, bit_cnt, FRAME_BITS);
    end
    tick();
    n_assert++;
    if (cap_en !== 1'b0 || frame_done !== 1'b1 || state !== 2'd3 || bit_cnt !== CNT_W'(FRAME_BITS)) begin
      n_fail++;
      $display("FAIL t1_wait_ack: cap_en=%0b done=%0b state=%0d bit_cnt=%0d want 0/1/3/%0d",
               cap_en, frame_done, state, bit_cnt, FRAME_BITS);
    end
    n_assert++;
    if (cap_pulses - p0 != FRAME_BITS || exp_q.size() != 0) begin
      n_fail++; $display("FAIL t1_pulse_count: got %0d pending %0d want %0d pending 0",
                         cap_pulses - p0, exp_q.size(), FRAME_BITS);
    end
  endtask

  task automatic test_lost_markers();
    int p0 = cap_pulses;
    send_marker(SYNC_WORD);
    send_marker(SYNC_WORD);
    n_assert++;
    if (lost_cnt !== 8'd2 || state !== 2'd3 || bit_cnt !== CNT_W'(FRAME_BITS)) begin
      n_fail++; $display("FAIL t4_lost_two: lost=%0d state=%0d bit_cnt=%0d want 2/3/%0d",
                         lost_cnt, state, bit_cnt, FRAME_BITS);
    end
    for (int i = 0; i < 298; i++) send_marker(SYNC_WORD);
    n_assert++;
    if (lost_cnt !== 8'd255 || state !== 2'd3) begin
      n_fail++; $display("FAIL t4_lost_saturate: lost=%0d state=%0d want 255/3", lost_cnt, state);
    end
    pulse_ack();
    n_assert++;
    if (state !== 2'd0 || frame_done !== 1'b0 || lost_cnt !== 8'd255 || cap_pulses != p0) begin
      n_fail++; $display("FAIL t4_ack: state=%0d done=%0b lost=%0d pulses=%0d want 0/0/255/0",
                         state, frame_done, lost_cnt, cap_pulses - p0);
    end
  endtask

  task automatic test_marker_errors();
    logic [31:0] bad;
    int p0 = cap_pulses;
    int a0 = abort_pulses;
    bad = SYNC_WORD ^ 32'h0000_0020;
    send_marker(bad);
`ifdef FRAME_SYNC_TOL_EN
    n_assert++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL t2_tol_capture: state=%0d want 1", state); end
    for (int k = 0; k < TIMEOUT_CYC + 20 && state != 2'd0; k++) tick();
    idle(2);
    n_assert++;
    if (state !== 2'd0 || abort_pulses - a0 != 1 || cap_pulses != p0) begin
      n_fail++; $display("FAIL t2_tol_abort: state=%0d aborts=%0d pulses=%0d want 0/1/0",
                         state, abort_pulses - a0, cap_pulses - p0);
    end
`else
    n_assert++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL t2_exact_reject: state=%0d want 0", state); end
    idle(4);
    n_assert++;
    if (state !== 2'd0 || cap_pulses != p0 || abort_pulses != a0) begin
      n_fail++; $display("FAIL t2_exact_idle: state=%0d pulses=%0d aborts=%0d want 0/0/0",
                         state, cap_pulses - p0, abort_pulses - a0);
    end
`endif
  endtask

  task automatic test_timeout();
    int p0 = cap_pulses;
    int a0 = abort_pulses;
    int hit = 0;
    bit done_seen = 1'b0;
    send_marker(SYNC_WORD);
    send_payload(100, 3, 1'b0);
    n_assert++;
    if (bit_cnt !== CNT_W'(100) || state !== 2'd1) begin
      n_fail++; $display("FAIL t3_partial: bit_cnt=%0d state=%0d want 100/1", bit_cnt, state);
    end
    for (int k = 1; k <= TIMEOUT_CYC + 50; k++) begin
      tick();
      if (frame_done) done_seen = 1'b1;
      if (frame_abort && hit == 0) hit = k;
      if (hit != 0 && k >= hit + 3) break;
    end
    n_assert++;
    if (hit != TIMEOUT_CYC) begin
      n_fail++; $display("FAIL t3_abort_time: abort after %0d idle clks want %0d", hit, TIMEOUT_CYC);
    end
    n_assert++;
    if (state !== 2'd0 || bit_cnt !== '0 || done_seen || frame_abort !== 1'b0) begin
      n_fail++; $display("FAIL t3_after_abort: state=%0d bit_cnt=%0d done_seen=%0b abort=%0b want 0/0/0/0",
                         state, bit_cnt, done_seen, frame_abort);
    end
    n_assert++;
    if (abort_pulses - a0 != 1 || cap_pulses - p0 != 100 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL t3_counts: aborts=%0d pulses=%0d pending=%0d want 1/100/0",
                         abort_pulses - a0, cap_pulses - p0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    send_marker(SYNC_WORD);
    send_payload(500, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if ({cap_en, cap_bit, frame_done, frame_abort, bit_cnt, state, lost_cnt} !== '0) begin
      n_fail++;
      $display("FAIL t5_async_reset: cap_en=%0b cap_bit=%0b done=%0b abort=%0b bit_cnt=%0d state=%0d lost=%0d, want all 0",
               cap_en, cap_bit, frame_done, frame_abort, bit_cnt, state, lost_cnt);
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    idle(2);
    p0 = cap_pulses;
    send_marker(SYNC_WORD);
    send_payload(FRAME_BITS, 0, 1'b0);
    idle(2);
    n_assert++;
    if (state !== 2'd3 || bit_cnt !== CNT_W'(FRAME_BITS) || cap_pulses - p0 != FRAME_BITS || exp_q.size() != 0) begin
      n_fail++; $display("FAIL t5_recapture: state=%0d bit_cnt=%0d pulses=%0d pending=%0d want 3/%0d/%0d/0",
                         state, bit_cnt, cap_pulses - p0, exp_q.size(), FRAME_BITS, FRAME_BITS);
    end
    pulse_ack();
    n_assert++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL t5_ack: state=%0d want 0", state); end
  endtask

  task automatic test_back_to_back();
    int p0 = cap_pulses;
    send_marker(SYNC_WORD);
    send_payload(FRAME_BITS, 0, 1'b0);
    tick();
    n_assert++;
    if (state !== 2'd3 || frame_done !== 1'b1) begin
      n_fail++; $display("FAIL t6_first_done: state=%0d done=%0b want 3/1", state, frame_done);
    end
    pulse_ack();
    send_marker(SYNC_WORD);
    send_payload(FRAME_BITS, 0, 1'b0);
    tick();
    n_assert++;
    if (state !== 2'd3 || bit_cnt !== CNT_W'(FRAME_BITS) || lost_cnt !== 8'd0) begin
      n_fail++; $display("FAIL t6_second_frame: state=%0d bit_cnt=%0d lost=%0d want 3/%0d/0",
                         state, bit_cnt, lost_cnt, FRAME_BITS);
    end
    n_assert++;
    if (cap_pulses - p0 != 2 * FRAME_BITS || exp_q.size() != 0) begin
      n_fail++; $display("FAIL t6_pulse_count: got %0d pending %0d want %0d",
                         cap_pulses - p0, exp_q.size(), 2 * FRAME_BITS);
    end
  endtask

  task automatic test_ack_with_match();
    logic [31:0] w = SYNC_WORD;
    int p0 = cap_pulses;
    for (int i = 31; i >= 1; i--) drive(w[i], 1'b0);
    drive(w[0], 1'b1);
    n_assert++;
    if (state !== 2'd0 || lost_cnt !== 8'd1 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL t7_ack_match: state=%0d lost=%0d done=%0b want 0/1/0",
                         state, lost_cnt, frame_done);
    end
    for (int i = 0; i < 8; i++) drive(1'($urandom()), 1'b0);
    n_assert++;
    if (state !== 2'd0 || cap_pulses != p0) begin
      n_fail++; $display("FAIL t7_no_capture: state=%0d pulses=%0d want 0/0", state, cap_pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_frame_slow();
    test_lost_markers();
    test_marker_errors();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    test_ack_with_match();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
